alu_arbiter: RTL and testbench

- Sequences the shared 64-bit combinational ALU between two requesters using valid/ready handshakes.
- Per request: latches one operation, drives the ALU operand and control ports from registers, waits a fixed settle time, captures the result and flags, and returns them with the requester ID.
- Sits between the two operand sources and the single ALU instance.

---
 rtl/alu_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters take turns on one shared combinational ALU.
// Each accepted operation is registered onto the ALU ports. The result and
// flags are captured ALU_LAT cycles later and held as a response until the
// consumer takes it. On a tie, the requester that was not served last wins.
// Optional statistics counters are built only when the macro
// ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
    parameter int WIDTH   = 64,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]      stat_cnt0,
    output logic [31:0]      stat_cnt1,
    output logic [15:0]      stat_err,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out
);

    // A zero settle time would capture before the registered operands reach the ALU.
    generate
        if (ALU_LAT < 1) begin : g_bad_lat
            $error("alu_arbiter: ALU_LAT must be >= 1");
        end
    endgenerate

    localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_id;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic [2:0]        r_alu_cntrl;
    logic              r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_result;
    logic [3:0]        r_rsp_flags;
    logic              r_rsp_err;

    logic              w_idle;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_acc;
    logic [2:0]        w_sel_op;
    logic              w_legal;
    logic              w_rsp_hs;

    // Codes 001 and 111 have no ALU meaning.
    function automatic logic is_legal(input logic [2:0] op);
        return (op != 3'b001) && (op != 3'b111);
    endfunction

    // Only add/sub produce meaningful overflow and carry; clear them for the rest.
    function automatic logic [3:0] mask_flags(input logic [2:0] op, input logic [3:0] f);
        if ((op == 3'b010) || (op == 3'b011))
            return f;
        else
            return {f[3:2], 2'b00};
    endfunction

    assign w_idle   = (r_state == S_IDLE);
    assign w_gnt0   = req0_valid && (!req1_valid || r_last_id);
    assign w_gnt1   = req1_valid && (!req0_valid || !r_last_id);
    assign w_acc0   = w_idle && w_gnt0;
    assign w_acc1   = w_idle && w_gnt1;
    assign w_acc    = w_acc0 || w_acc1;
    assign w_sel_op = w_acc1 ? req1_op : req0_op;
    assign w_legal  = is_legal(w_sel_op);
    assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;

    assign req0_ready = w_acc0;
    assign req1_ready = w_acc1;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_cntrl  = r_alu_cntrl;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next state: illegal ops skip the settle wait and answer at once.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_acc) w_next = w_legal ? S_EXEC : S_RESP;
            S_EXEC: if (r_cnt == CW'(1)) w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operation latch on accept and result capture when the settle count expires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_id    <= 1'b1;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cntrl  <= 3'b000;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
            r_rsp_err    <= 1'b0;
        end else if (w_acc) begin
            r_alu_a     <= w_acc1 ? req1_a : req0_a;
            r_alu_b     <= w_acc1 ? req1_b : req0_b;
            r_alu_cntrl <= w_sel_op;
            r_rsp_id    <= w_acc1;
            r_last_id   <= w_acc1;
            r_cnt       <= CW'(ALU_LAT);
            if (!w_legal) begin
                r_rsp_err    <= 1'b1;
                r_rsp_result <= '0;
                r_rsp_flags  <= 4'b0000;
            end
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= mask_flags(r_alu_cntrl,
                                           {alu_negative, alu_zero, alu_overflow, alu_carry_out});
                r_rsp_err    <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [31:0] r_stat_cnt0;
    logic [31:0] r_stat_cnt1;
    logic [15:0] r_stat_err;

    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    // Completed handshakes per requester and illegal ops seen at accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_cnt0 <= '0;
            r_stat_cnt1 <= '0;
            r_stat_err  <= '0;
        end else begin
            if (w_rsp_hs) begin
                if (r_rsp_id)
                    r_stat_cnt1 <= sat_inc32(r_stat_cnt1);
                else
                    r_stat_cnt0 <= sat_inc32(r_stat_cnt0);
            end
            if (w_acc && !w_legal)
                r_stat_err <= sat_inc16(r_stat_err);
        end
    end

    assign stat_cnt0 = r_stat_cnt0;
    assign stat_cnt1 = r_stat_cnt1;
    assign stat_err  = r_stat_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Instance dut uses ALU_LAT=1 and instance
// dut3 uses ALU_LAT=3. Each instance drives its own behavioural ALU stub.
// For non-arithmetic ops the stubs report overflow and carry as 1, so the
// arbiter's flag masking is exercised. For illegal codes they return a
// marker value that must never be captured.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        v0, v1, w0, w1, rsp_ready;
    logic [2:0]  op0, op1;
    logic [63:0] a0, b0, a1, b1;

    logic        d_req0_ready, d_req1_ready, d_rsp_valid, d_rsp_id, d_rsp_err;
    logic [63:0] d_rsp_result, d_alu_a, d_alu_b, d_res;
    logic [3:0]  d_rsp_flags;
    logic [2:0]  d_alu_cntrl;
    logic        d_n, d_z, d_v, d_c;

    logic        e_req0_ready, e_req1_ready, e_rsp_valid, e_rsp_id, e_rsp_err;
    logic [63:0] e_rsp_result, e_alu_a, e_alu_b, e_res;
    logic [3:0]  e_rsp_flags;
    logic [2:0]  e_alu_cntrl;
    logic        e_n, e_z, e_v, e_c;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] d_stat_cnt0, d_stat_cnt1, e_stat_cnt0, e_stat_cnt1;
    logic [15:0] d_stat_err, e_stat_err;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural ALU returning {N, Z, V, C, result}.
    function automatic logic [67:0] alu_model(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        logic [63:0] r;
        logic        v, co;
        s = '0; r = '0; v = 1'b1; co = 1'b1;
        case (c)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0]; co = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = s[63:0]; co = s[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
        return {r[63], (r == 64'd0), v, co, r};
    endfunction

    assign {d_n, d_z, d_v, d_c, d_res} = alu_model(d_alu_cntrl, d_alu_a, d_alu_b);
    assign {e_n, e_z, e_v, e_c, e_res} = alu_model(e_alu_cntrl, e_alu_a, e_alu_b);

    alu_arbiter #(.WIDTH(64), .ALU_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(v0), .req0_ready(d_req0_ready), .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(d_req1_ready), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(d_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d_rsp_id),
        .rsp_result(d_rsp_result), .rsp_flags(d_rsp_flags), .rsp_err(d_rsp_err),
`ifdef ALU_ARB_STATS_EN
        .stat_cnt0(d_stat_cnt0), .stat_cnt1(d_stat_cnt1), .stat_err(d_stat_err),
`endif
        .alu_a(d_alu_a), .alu_b(d_alu_b), .alu_cntrl(d_alu_cntrl),
        .alu_result(d_res), .alu_negative(d_n), .alu_zero(d_z),
        .alu_overflow(d_v), .alu_carry_out(d_c)
    );

    alu_arbiter #(.WIDTH(64), .ALU_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(w0), .req0_ready(e_req0_ready), .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_valid(w1), .req1_ready(e_req1_ready), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(e_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(e_rsp_id),
        .rsp_result(e_rsp_result), .rsp_flags(e_rsp_flags), .rsp_err(e_rsp_err),
`ifdef ALU_ARB_STATS_EN
        .stat_cnt0(e_stat_cnt0), .stat_cnt1(e_stat_cnt1), .stat_err(e_stat_err),
`endif
        .alu_a(e_alu_a), .alu_b(e_alu_b), .alu_cntrl(e_alu_cntrl),
        .alu_result(e_res), .alu_negative(e_n), .alu_zero(e_z),
        .alu_overflow(e_v), .alu_carry_out(e_c)
    );

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0h exp=0", d_rsp_valid); end
        checks++; if (d_rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%0h exp=0", d_rsp_id); end
        checks++; if (d_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%0h exp=0", d_rsp_err); end
        checks++; if (d_rsp_result !== 64'd0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", d_rsp_result); end
        checks++; if (d_rsp_flags !== 4'd0) begin errors++; $display("FAIL reset_rsp_flags got=%b exp=0000", d_rsp_flags); end
        checks++; if (d_alu_a !== 64'd0 || d_alu_b !== 64'd0) begin errors++; $display("FAIL reset_alu_ab got=%h/%h exp=0/0", d_alu_a, d_alu_b); end
        checks++; if (d_alu_cntrl !== 3'b000) begin errors++; $display("FAIL reset_alu_cntrl got=%b exp=000", d_alu_cntrl); end
        checks++; if (e_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid3 got=%0h exp=0", e_rsp_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        v0 = 1'b1; op0 = 3'b010; a0 = 64'd1; b0 = 64'd1; rsp_ready = 1'b1;
        #1;
        checks++; if (d_req0_ready !== 1'b1 || d_req1_ready !== 1'b0) begin errors++; $display("FAIL add_ready got=%0h%0h exp=10", d_req0_ready, d_req1_ready); end
        @(posedge clk); #1;
        v0 = 1'b0;
        checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got=%0h exp=0", d_rsp_valid); end
        checks++; if (d_alu_a !== 64'd1 || d_alu_b !== 64'd1 || d_alu_cntrl !== 3'b010) begin errors++; $display("FAIL add_alu_ports got=%h/%h/%b exp=1/1/010", d_alu_a, d_alu_b, d_alu_cntrl); end
        checks++; if (d_req0_ready !== 1'b0) begin errors++; $display("FAIL add_busy_ready got=%0h exp=0", d_req0_ready); end
        @(posedge clk); #1;
        checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0h exp=1", d_rsp_valid); end
        checks++; if (d_rsp_result !== 64'd2) begin errors++; $display("FAIL add_result got=%h exp=2", d_rsp_result); end
        checks++; if (d_rsp_flags !== 4'b0000) begin errors++; $display("FAIL add_flags got=%b exp=0000", d_rsp_flags); end
        checks++; if (d_rsp_id !== 1'b0 || d_rsp_err !== 1'b0) begin errors++; $display("FAIL add_id_err got=%0h/%0h exp=0/0", d_rsp_id, d_rsp_err); end
        @(posedge clk); #1;
        checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL add_release got=%0h exp=0", d_rsp_valid); end
    endtask

    task automatic test_alternate();
        logic       exp_id;
        logic [3:0] exp_flags;
        apply_reset();
        v0 = 1'b1; op0 = 3'b011; a0 = 64'd1; b0 = 64'd1;
        v1 = 1'b1; op1 = 3'b110; a1 = 64'h1010_1010_1010_1010; b1 = 64'h1010_1010_1010_1010;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id    = (k % 2 == 1);
            exp_flags = exp_id ? 4'b0100 : 4'b0101;
            checks++; if (d_req0_ready !== !exp_id || d_req1_ready !== exp_id) begin errors++; $display("FAIL alt_grant%0d got=%0h%0h exp_id=%0d", k, d_req0_ready, d_req1_ready, exp_id); end
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++; if (d_rsp_valid !== 1'b1 || d_rsp_id !== exp_id) begin errors++; $display("FAIL alt_rsp%0d got valid=%0h id=%0h exp 1/%0d", k, d_rsp_valid, d_rsp_id, exp_id); end
            checks++; if (d_rsp_result !== 64'd0 || d_rsp_flags !== exp_flags) begin errors++; $display("FAIL alt_data%0d got=%h/%b exp=0/%b", k, d_rsp_result, d_rsp_flags, exp_flags); end
            @(posedge clk); #1;
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_logic_ops();
        logic [2:0]  t_op  [4];
        logic [63:0] t_a   [4];
        logic [63:0] t_b   [4];
        logic [63:0] t_res [4];
        logic [3:0]  t_fl  [4];
        t_op[0] = 3'b000; t_a[0] = 64'd5;    t_b[0] = 64'h8000_0000_0000_0000; t_res[0] = 64'h8000_0000_0000_0000; t_fl[0] = 4'b1000;
        t_op[1] = 3'b100; t_a[1] = 64'hF0;   t_b[1] = 64'h3C;                  t_res[1] = 64'h30;                  t_fl[1] = 4'b0000;
        t_op[2] = 3'b101; t_a[2] = 64'hF0;   t_b[2] = 64'h3C;                  t_res[2] = 64'hFC;                  t_fl[2] = 4'b0000;
        t_op[3] = 3'b011; t_a[3] = 64'd0;    t_b[3] = 64'd1;                   t_res[3] = 64'hFFFF_FFFF_FFFF_FFFF; t_fl[3] = 4'b1000;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v1 = 1'b1; op1 = t_op[k]; a1 = t_a[k]; b1 = t_b[k];
            #1;
            checks++; if (d_req1_ready !== 1'b1) begin errors++; $display("FAIL op%0d_ready got=%0h exp=1", k, d_req1_ready); end
            @(posedge clk); #1;
            v1 = 1'b0;
            @(posedge clk); #1;
            checks++; if (d_rsp_result !== t_res[k] || d_rsp_flags !== t_fl[k] || d_rsp_id !== 1'b1) begin errors++; $display("FAIL op%0d_rsp got=%h/%b/%0h exp=%h/%b/1", k, d_rsp_result, d_rsp_flags, d_rsp_id, t_res[k], t_fl[k]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        v1 = 1'b1; op1 = 3'b010; a1 = 64'h7FFF_FFFF_FFFF_FFFF; b1 = 64'h7FFF_FFFF_FFFF_FFFF;
        #1;
        checks++; if (d_req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%0h exp=1", d_req1_ready); end
        @(posedge clk); #1;
        v1 = 1'b0;
        v0 = 1'b1; op0 = 3'b010; a0 = 64'd1; b0 = 64'd2;
        #1;
        checks++; if (d_req0_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_ready0 got=%0h exp=0", d_req0_ready); end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (d_rsp_valid !== 1'b1 || d_rsp_id !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got valid=%0h id=%0h exp 1/1", i, d_rsp_valid, d_rsp_id); end
            checks++; if (d_rsp_result !== 64'hFFFF_FFFF_FFFF_FFFE || d_rsp_flags !== 4'b1010) begin errors++; $display("FAIL bp_data%0d got=%h/%b exp=fffffffffffffffe/1010", i, d_rsp_result, d_rsp_flags); end
            checks++; if (d_req0_ready !== 1'b0) begin errors++; $display("FAIL bp_wait%0d got=%0h exp=0", i, d_req0_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (d_rsp_valid !== 1'b1 || d_req0_ready !== 1'b0) begin errors++; $display("FAIL bp_last got=%0h/%0h exp=1/0", d_rsp_valid, d_req0_ready); end
        @(posedge clk); #1;
        checks++; if (d_rsp_valid !== 1'b0 || d_req0_ready !== 1'b1) begin errors++; $display("FAIL bp_after got=%0h/%0h exp=0/1", d_rsp_valid, d_req0_ready); end
        @(posedge clk); #1;
        v0 = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_rsp_result !== 64'd3 || d_rsp_id !== 1'b0 || d_rsp_flags !== 4'b0000) begin errors++; $display("FAIL bp_req0 got=%h/%0h/%b exp=3/0/0000", d_rsp_result, d_rsp_id, d_rsp_flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        rsp_ready = 1'b1;
        v0 = 1'b1; op0 = 3'b111; a0 = 64'd5; b0 = 64'd6;
        #1;
        checks++; if (d_req0_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got=%0h exp=1", d_req0_ready); end
        @(posedge clk); #1;
        v0 = 1'b0;
        checks++; if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1) begin errors++; $display("FAIL ill_rsp got valid=%0h err=%0h exp 1/1", d_rsp_valid, d_rsp_err); end
        checks++; if (d_rsp_result !== 64'd0 || d_rsp_flags !== 4'b0000) begin errors++; $display("FAIL ill_data got=%h/%b exp=0/0000", d_rsp_result, d_rsp_flags); end
        checks++; if (d_alu_cntrl !== 3'b111 || d_alu_a !== 64'd5) begin errors++; $display("FAIL ill_ports got=%b/%h exp=111/5", d_alu_cntrl, d_alu_a); end
        @(posedge clk); #1;
        checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_release got=%0h exp=0", d_rsp_valid); end
        v0 = 1'b1; op0 = 3'b010; a0 = 64'd2; b0 = 64'd3;
        @(posedge clk); #1;
        v0 = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_rsp_err !== 1'b0 || d_rsp_result !== 64'd5) begin errors++; $display("FAIL ill_next got err=%0h res=%h exp 0/5", d_rsp_err, d_rsp_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        w0 = 1'b1; op0 = 3'b010; a0 = 64'd3; b0 = 64'd4;
        #1;
        checks++; if (e_req0_ready !== 1'b1) begin errors++; $display("FAIL lat3_ready got=%0h exp=1", e_req0_ready); end
        @(posedge clk); #1;
        w0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (e_rsp_valid !== 1'b0) begin errors++; $display("FAIL lat3_early%0d got=%0h exp=0", i, e_rsp_valid); end
            @(posedge clk); #1;
        end
        checks++; if (e_rsp_valid !== 1'b1 || e_rsp_result !== 64'd7 || e_rsp_id !== 1'b0) begin errors++; $display("FAIL lat3_rsp got=%0h/%h/%0h exp=1/7/0", e_rsp_valid, e_rsp_result, e_rsp_id); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (e_rsp_valid !== 1'b0 || e_rsp_result !== 64'd0) begin errors++; $display("FAIL rst_resp got=%0h/%h exp=0/0", e_rsp_valid, e_rsp_result); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        w0 = 1'b1; op0 = 3'b010; a0 = 64'd1; b0 = 64'd1;
        @(posedge clk); #1;
        w0 = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (e_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec got=%0h exp=0", e_rsp_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        w0 = 1'b1; w1 = 1'b1; op1 = 3'b010; a1 = 64'd9; b1 = 64'd9;
        #1;
        checks++; if (e_req0_ready !== 1'b1 || e_req1_ready !== 1'b0) begin errors++; $display("FAIL rst_prio got=%0h%0h exp=10", e_req0_ready, e_req1_ready); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        w0 = 1'b0; w1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic do_op(input bit id, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n;
        if (id) begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else    begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!(id ? d_req1_ready : d_req0_ready) && n < 10) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 10) begin errors++; $display("FAIL stats_grant timeout got=none exp=grant"); end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        n = 0;
        while (!d_rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 10) begin errors++; $display("FAIL stats_rsp timeout got=none exp=rsp"); end
        @(posedge clk); #1;
    endtask

    task automatic test_stats();
        apply_reset();
        checks++; if (d_stat_cnt0 !== 32'd0 || d_stat_cnt1 !== 32'd0 || d_stat_err !== 16'd0) begin errors++; $display("FAIL stats_reset got=%0d/%0d/%0d exp=0/0/0", d_stat_cnt0, d_stat_cnt1, d_stat_err); end
        do_op(1'b0, 3'b010, 64'd1, 64'd1);
        do_op(1'b1, 3'b110, 64'd3, 64'd5);
        do_op(1'b0, 3'b100, 64'd7, 64'd1);
        do_op(1'b1, 3'b001, 64'd2, 64'd2);
        do_op(1'b0, 3'b000, 64'd0, 64'd4);
        checks++; if (d_stat_cnt0 !== 32'd3) begin errors++; $display("FAIL stats_cnt0 got=%0d exp=3", d_stat_cnt0); end
        checks++; if (d_stat_cnt1 !== 32'd2) begin errors++; $display("FAIL stats_cnt1 got=%0d exp=2", d_stat_cnt1); end
        checks++; if (d_stat_err !== 16'd1) begin errors++; $display("FAIL stats_err got=%0d exp=1", d_stat_err); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; v0 = 1'b0; v1 = 1'b0; w0 = 1'b0; w1 = 1'b0; rsp_ready = 1'b0;
        op0 = 3'b000; op1 = 3'b000; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single_add();
        test_alternate();
        test_logic_ops();
        test_backpressure();
        test_illegal();
        test_reset_mid();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
